dma_priority_resolver: RTL and testbench

//  Priority/arbitration stage of the DMA controller. Collects channel DREQs, raises HRQ to the CPU,

---
 rtl/dma_priority_resolver.sv | 140 ++++++++++++++
 tb/tb_dma_priority_resolver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_resolver.sv
// DMA priority/arbitration stage: collects DREQs, raises HRQ, picks the winner on HLDA, drives DACK.
// Optional build macro DMA_SW_REQUEST_EN adds a software request input that bypasses the mask.
module dma_priority_resolver #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic              assertDACK,
  input  logic              deassertDACK,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              controllerDisable,
  input  logic              rotatingPriority,
  input  logic              dreqSenseLow,
  input  logic              dackSenseHigh,
`ifdef DMA_SW_REQUEST_EN
  input  logic [NUM_CH-1:0] softwareReq,
`endif
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   activeChannel,
  output logic              validRequest
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_ACTIVE
  } state_t;

  state_t            r_state;
  logic              r_hrq;
  logic              r_valid;
  logic [NUM_CH-1:0] r_dack_active;
  logic [CH_W-1:0]   r_active_ch;
  logic [CH_W-1:0]   r_ptr;

  logic [NUM_CH-1:0] w_eff_req;
  logic              w_any_req;
  logic [CH_W-1:0]   w_base;
  logic [CH_W-1:0]   w_winner;
  logic              w_found;
  int                w_idx;
  logic [NUM_CH-1:0] w_dack_onehot;
  logic [CH_W-1:0]   w_ptr_next;

`ifdef DMA_SW_REQUEST_EN
  // Software requests skip the mask but still honour the controller disable bit.
  assign w_eff_req = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg | softwareReq)
                     & {NUM_CH{~controllerDisable}};
`else
  assign w_eff_req = (DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg & {NUM_CH{~controllerDisable}};
`endif

  assign w_any_req = |w_eff_req;

  // Search starts at the highest-priority channel (ch0 in fixed mode) and wraps around.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    w_base   = rotatingPriority ? r_ptr : '0;
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = int'(w_base) + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_found && w_eff_req[w_idx]) begin
        w_winner = CH_W'(w_idx);
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_dack_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_dack_onehot[i] = (r_active_ch == CH_W'(i));
    end
  end

  assign w_ptr_next = (r_active_ch == CH_W'(NUM_CH - 1)) ? '0 : r_active_ch + 1'b1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state       <= S_IDLE;
      r_hrq         <= 1'b0;
      r_valid       <= 1'b0;
      r_dack_active <= '0;
      r_active_ch   <= '0;
      r_ptr         <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same clock edge.
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_hrq   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (HLDA && w_any_req) begin
            r_active_ch <= w_winner;
            r_valid     <= 1'b1;
            r_state     <= S_GRANT;
          end else if (!w_any_req) begin
            r_hrq   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_GRANT, S_ACTIVE: begin
          if (!HLDA) begin
            r_hrq         <= 1'b0;
            r_dack_active <= '0;
            r_state       <= S_IDLE;
          end else if (deassertDACK) begin
            // End of service; also wins over a simultaneous assertDACK in GRANT.
            r_hrq         <= 1'b0;
            r_dack_active <= '0;
            if (rotatingPriority) r_ptr <= w_ptr_next;
            r_state       <= S_IDLE;
          end else if (assertDACK && (r_state == S_GRANT)) begin
            r_dack_active <= w_dack_onehot;
            r_state       <= S_ACTIVE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HRQ           = r_hrq;
  assign validRequest  = r_valid;
  assign activeChannel = r_active_ch;
  assign DACK          = dackSenseHigh ? r_dack_active : ~r_dack_active;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed bench for dma_priority_resolver: reset, fixed/rotating priority, mask/sense, aborts.
module tb_dma_priority_resolver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic       assertDACK;
  logic       deassertDACK;
  logic [3:0] maskReg;
  logic       controllerDisable;
  logic       rotatingPriority;
  logic       dreqSenseLow;
  logic       dackSenseHigh;
`ifdef DMA_SW_REQUEST_EN
  logic [3:0] softwareReq;
`endif
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeChannel;
  logic       validRequest;

  int total = 0;
  int bad   = 0;

  dma_priority_resolver #(.NUM_CH(4), .CH_W(2)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .DREQ              (DREQ),
    .HLDA              (HLDA),
    .assertDACK        (assertDACK),
    .deassertDACK      (deassertDACK),
    .maskReg           (maskReg),
    .controllerDisable (controllerDisable),
    .rotatingPriority  (rotatingPriority),
    .dreqSenseLow      (dreqSenseLow),
    .dackSenseHigh     (dackSenseHigh),
`ifdef DMA_SW_REQUEST_EN
    .softwareReq       (softwareReq),
`endif
    .HRQ               (HRQ),
    .DACK              (DACK),
    .activeChannel     (activeChannel),
    .validRequest      (validRequest)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Full request/grant/service cycle for one channel; leaves DUT idle with requests removed.
  task automatic serve(input string tag, input logic [3:0] req, input logic [1:0] exp_ch);
    logic [3:0] onehot;
    logic [3:0] dack_on;
    logic [3:0] dack_off;
    onehot   = 4'b0001 << exp_ch;
    dack_on  = dackSenseHigh ? onehot : ~onehot;
    dack_off = dackSenseHigh ? 4'h0 : 4'hF;
    DREQ = req;
    HLDA = 1'b0;
    tick();
    check({tag, "_hrq"}, 32'(HRQ), 32'd1);
    HLDA = 1'b1;
    tick();
    check({tag, "_ch"}, 32'(activeChannel), 32'(exp_ch));
    check({tag, "_valid"}, 32'(validRequest), 32'd1);
    assertDACK = 1'b1;
    tick();
    assertDACK = 1'b0;
    DREQ = dreqSenseLow ? 4'hF : 4'h0;
    check({tag, "_valid_pulse"}, 32'(validRequest), 32'd0);
    check({tag, "_dack_on"}, 32'(DACK), 32'(dack_on));
    tick();
    check({tag, "_dack_hold"}, 32'(DACK), 32'(dack_on));
    deassertDACK = 1'b1;
    tick();
    deassertDACK = 1'b0;
    HLDA = 1'b0;
    check({tag, "_dack_off"}, 32'(DACK), 32'(dack_off));
    check({tag, "_hrq_off"}, 32'(HRQ), 32'd0);
  endtask

  initial begin
    RESET = 1'b0;
    DREQ = 4'h0;
    HLDA = 1'b0;
    assertDACK = 1'b0;
    deassertDACK = 1'b0;
    maskReg = 4'h0;
    controllerDisable = 1'b0;
    rotatingPriority = 1'b0;
    dreqSenseLow = 1'b0;
    dackSenseHigh = 1'b0;
`ifdef DMA_SW_REQUEST_EN
    softwareReq = 4'h0;
`endif
    #12;
    check("rst_hrq", 32'(HRQ), 32'd0);
    check("rst_dack", 32'(DACK), 32'hF);
    check("rst_ch", 32'(activeChannel), 32'd0);
    check("rst_valid", 32'(validRequest), 32'd0);
    RESET = 1'b1;
    tick();

    // Asynchronous reset in the middle of an ACTIVE transfer on ch2.
    DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    assertDACK = 1'b1;
    tick();
    assertDACK = 1'b0;
    check("pre_rst_dack", 32'(DACK), 32'b1011);
    RESET = 1'b0;
    #1;
    check("async_rst_hrq", 32'(HRQ), 32'd0);
    check("async_rst_dack", 32'(DACK), 32'hF);
    check("async_rst_ch", 32'(activeChannel), 32'd0);
    #3;
    RESET = 1'b1;
    HLDA = 1'b0;
    DREQ = 4'h0;
    tick();
    check("post_rst_hrq", 32'(HRQ), 32'd0);
    DREQ = 4'b0001;
    tick();
    check("post_rst_idle_req", 32'(HRQ), 32'd1);
    DREQ = 4'h0;
    tick();
    check("req_drop_hrq", 32'(HRQ), 32'd0);
    check("req_drop_valid", 32'(validRequest), 32'd0);

    // assertDACK while idle is ignored.
    assertDACK = 1'b1;
    tick();
    assertDACK = 1'b0;
    check("idle_assert_dack", 32'(DACK), 32'hF);

    // Fixed priority.
    serve("fixed_1010", 4'b1010, 2'd1);
    serve("fixed_1100", 4'b1100, 2'd2);

    // Rotating priority, including pointer wrap from ch3 to ch0.
    rotatingPriority = 1'b1;
    serve("rot_1010", 4'b1010, 2'd1);
    serve("rot_0011", 4'b0011, 2'd0);
    serve("rot_1000", 4'b1000, 2'd3);
    serve("rot_wrap_1001", 4'b1001, 2'd0);
    rotatingPriority = 1'b0;
    serve("fixed_again_0011", 4'b0011, 2'd0);

    // Masking, controller disable, DREQ sense.
    maskReg = 4'b0001;
    DREQ = 4'b0001;
    tick();
    tick();
    check("masked_hrq", 32'(HRQ), 32'd0);
    maskReg = 4'h0;
    controllerDisable = 1'b1;
    tick();
    tick();
    check("disabled_hrq", 32'(HRQ), 32'd0);
    controllerDisable = 1'b0;
    DREQ = 4'h0;
    dreqSenseLow = 1'b1;
    DREQ = 4'hF;
    tick();
    check("sense_low_idle_hrq", 32'(HRQ), 32'd0);
    serve("sense_low_1110", 4'b1110, 2'd0);
    dreqSenseLow = 1'b0;
    DREQ = 4'h0;
    tick();
    check("sense_restore_hrq", 32'(HRQ), 32'd0);

    // Active-high DACK.
    dackSenseHigh = 1'b1;
    #1;
    check("dack_high_idle", 32'(DACK), 32'h0);
    serve("dack_high_0100", 4'b0100, 2'd2);
    dackSenseHigh = 1'b0;

    // Winner frozen in GRANT despite a later higher-priority request.
    DREQ = 4'b1000;
    tick();
    HLDA = 1'b1;
    tick();
    DREQ = 4'b1001;
    tick();
    assertDACK = 1'b1;
    tick();
    assertDACK = 1'b0;
    check("no_preempt_ch", 32'(activeChannel), 32'd3);
    check("no_preempt_dack", 32'(DACK), 32'b0111);
    DREQ = 4'h0;
    deassertDACK = 1'b1;
    tick();
    deassertDACK = 1'b0;
    HLDA = 1'b0;
    check("no_preempt_end", 32'(DACK), 32'hF);

    // HLDA falls during ACTIVE.
    DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    check("abort_grant_ch", 32'(activeChannel), 32'd2);
    assertDACK = 1'b1;
    tick();
    assertDACK = 1'b0;
    DREQ = 4'h0;
    check("abort_active_dack", 32'(DACK), 32'b1011);
    HLDA = 1'b0;
    tick();
    check("abort_dack", 32'(DACK), 32'hF);
    check("abort_hrq", 32'(HRQ), 32'd0);

    // Simultaneous assert/deassert in GRANT: DACK never asserted.
    DREQ = 4'b0100;
    tick();
    HLDA = 1'b1;
    tick();
    assertDACK = 1'b1;
    deassertDACK = 1'b1;
    DREQ = 4'h0;
    tick();
    assertDACK = 1'b0;
    deassertDACK = 1'b0;
    check("both_dack", 32'(DACK), 32'hF);
    check("both_hrq", 32'(HRQ), 32'd0);
    tick();
    check("both_dack_later", 32'(DACK), 32'hF);
    HLDA = 1'b0;

`ifdef DMA_SW_REQUEST_EN
    // Software request bypasses the mask.
    maskReg = 4'hF;
    softwareReq = 4'b0100;
    tick();
    check("sw_hrq", 32'(HRQ), 32'd1);
    HLDA = 1'b1;
    tick();
    check("sw_ch", 32'(activeChannel), 32'd2);
    softwareReq = 4'h0;
    HLDA = 1'b0;
    tick();
    check("sw_abort_hrq", 32'(HRQ), 32'd0);
    maskReg = 4'h0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
